// File: rtl/code_sel_pkg.sv
// Shared constants, types and helpers for the code-status event encoder.
package code_sel_pkg;

    localparam int N_CODES = 18;                 // status bits; bit k maps to code k+1
    localparam int CODE_W  = 6;                  // code width, holds 1..N_CODES
    localparam int CNT_W   = 16;                 // saturating counter width
    localparam int IDX_W   = $clog2(N_CODES);    // bit-index width

    typedef logic [N_CODES-1:0] status_t;
    typedef logic [CODE_W-1:0]  code_t;

    // Bit index k becomes code k+1 (code 0 is never emitted).
    function automatic code_t idx_to_code(input logic [IDX_W-1:0] idx);
        return code_t'(idx) + code_t'(1);
    endfunction

endpackage

// File: rtl/code_prio_enc.sv
// Lowest-set-bit priority encoder: reports whether any bit is set, the index
// of the lowest set bit, and that bit isolated as a one-hot mask.
module code_prio_enc #(
    parameter int N     = 18,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec_i,
    output logic             found_o,
    output logic [IDX_W-1:0] index_o,
    output logic [N-1:0]     onehot_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                found_o = 1'b1;
                index_o = IDX_W'(i);
            end
        end
    end

    // Two's-complement trick isolates the lowest set bit.
    assign onehot_o = vec_i & (~vec_i + N'(1));

endmodule

// File: rtl/code_status_event_enc.sv
// Code status event encoder: turns newly asserted status bits into code
// events (1..N_CODES) on a valid/ready stream, merging repeated rises of a
// bit that is still waiting for output. Optional macro STATUS_FALL_EVENT_EN
// adds fall events (code_dir_o = 0), which lose arbitration to any rise.
module code_status_event_enc
    import code_sel_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_CODES-1:0] status_i,
    output logic [CODE_W-1:0]  code_o,
    output logic               code_dir_o,
    output logic               code_val_o,
    input  logic               code_ready_i,
    output logic [N_CODES-1:0] pending_o,
    output logic [CNT_W-1:0]   evt_cnt_o,
    output logic [CNT_W-1:0]   merged_cnt_o
);

    // Handshake: an event transfers on a cycle where code_val_o & code_ready_i.
    // Once code_val_o is high, code_o/code_dir_o stay put until that transfer;
    // code_val_o never drops without a transfer (except on reset).

    status_t    status_q;
    status_t    pend_q, pend_d;
    code_t      code_q, code_d;
    logic       dir_q, dir_d;
    logic       val_q, val_d;
    logic [CNT_W-1:0] evt_q, evt_d;
    logic [CNT_W-1:0] merged_q, merged_d;

    status_t    rise;
    status_t    load_mask;
    logic       slot_free;
    logic       handshake;
    logic       merge_hit;

    logic             rise_found;
    logic [IDX_W-1:0] rise_idx;
    status_t          rise_onehot;

    assign rise      = status_i & ~status_q;
    assign handshake = val_q & code_ready_i;
    assign slot_free = ~val_q | code_ready_i;

    code_prio_enc #(.N(N_CODES), .IDX_W(IDX_W)) u_rise_enc (
        .vec_i    (pend_q),
        .found_o  (rise_found),
        .index_o  (rise_idx),
        .onehot_o (rise_onehot)
    );

`ifdef STATUS_FALL_EVENT_EN
    status_t          pend_fall_q, pend_fall_d;
    status_t          fall;
    status_t          load_fall;
    logic             fall_found;
    logic [IDX_W-1:0] fall_idx;
    status_t          fall_onehot;

    assign fall = ~status_i & status_q;

    code_prio_enc #(.N(N_CODES), .IDX_W(IDX_W)) u_fall_enc (
        .vec_i    (pend_fall_q),
        .found_o  (fall_found),
        .index_o  (fall_idx),
        .onehot_o (fall_onehot)
    );
`endif

    // Output slot loading: rises first (lowest index), then falls if enabled.
    always_comb begin
        code_d    = code_q;
        dir_d     = dir_q;
        val_d     = val_q;
        load_mask = '0;
`ifdef STATUS_FALL_EVENT_EN
        load_fall = '0;
`endif
        if (slot_free) begin
            val_d = 1'b0;
            if (rise_found) begin
                code_d    = idx_to_code(rise_idx);
                dir_d     = 1'b1;
                val_d     = 1'b1;
                load_mask = rise_onehot;
            end
`ifdef STATUS_FALL_EVENT_EN
            else if (fall_found) begin
                code_d    = idx_to_code(fall_idx);
                dir_d     = 1'b0;
                val_d     = 1'b1;
                load_fall = fall_onehot;
            end
`endif
        end
    end

    // Pending vectors, merge detection and saturating counters.
    always_comb begin
        pend_d    = (pend_q & ~load_mask) | rise;
        merge_hit = |(rise & pend_q & ~load_mask);
`ifdef STATUS_FALL_EVENT_EN
        pend_fall_d = (pend_fall_q & ~load_fall) | fall;
        merge_hit   = merge_hit | (|(fall & pend_fall_q & ~load_fall));
`endif
        evt_d    = evt_q;
        merged_d = merged_q;
        if (handshake && (evt_q != '1)) begin
            evt_d = evt_q + CNT_W'(1);
        end
        if (merge_hit && (merged_q != '1)) begin
            merged_d = merged_q + CNT_W'(1);
        end
    end

    // State registers, cleared asynchronously by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            status_q <= '0;
            pend_q   <= '0;
            code_q   <= '0;
            dir_q    <= 1'b0;
            val_q    <= 1'b0;
            evt_q    <= '0;
            merged_q <= '0;
        end else begin
            status_q <= status_i;
            pend_q   <= pend_d;
            code_q   <= code_d;
            dir_q    <= dir_d;
            val_q    <= val_d;
            evt_q    <= evt_d;
            merged_q <= merged_d;
        end
    end

`ifdef STATUS_FALL_EVENT_EN
    // Fall-event pending register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_fall_q <= '0;
        end else begin
            pend_fall_q <= pend_fall_d;
        end
    end

    assign pending_o = pend_q | pend_fall_q;
`else
    assign pending_o = pend_q;
`endif

    assign code_o       = code_q;
    assign code_dir_o   = dir_q;
    assign code_val_o   = val_q;
    assign evt_cnt_o    = evt_q;
    assign merged_cnt_o = merged_q;

endmodule
